// File: rtl/bubble_sort_engine_if.sv
// Host-side bus of the bubble sort engine.
// Groups the control, array-access and status signals of bubble_sort_engine.
//   master : host view (drives start/config/write/read address, observes status)
//   slave  : engine view
// Signals:
//   start, descend, signed_cmp, len   sort request and its configuration
//   wr_en, wr_addr, wr_data           host array write port
//   rd_addr, rd_data                  host array read port (combinational)
//   busy, done, swap_count, pass_count status of the last or current sort
interface bubble_sort_engine_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             descend;
    logic             signed_cmp;
    logic [AW:0]      len;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] swap_count;
    logic [AW:0]      pass_count;

    modport master (
        output start, descend, signed_cmp, len, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, swap_count, pass_count
    );

    modport slave (
        input  start, descend, signed_cmp, len, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, swap_count, pass_count
    );
endinterface

// File: rtl/bubble_sort_engine.sv
// In-place bubble sort accelerator over a local DEPTH x WIDTH array.
// The host loads/reads the array through the bus; a start pulse sorts the first
// len entries ascending or descending, signed or unsigned, stopping early after
// a pass with no swaps.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (array contents are not reset)
//   bus    bubble_sort_engine_if slave modport (config, array access, status)
module bubble_sort_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    bubble_sort_engine_if.slave bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCmp  = 2'd1;
    localparam logic [1:0] StSwap = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      limit_q, limit_d;
    logic             swapped_q, swapped_d;
    logic             descend_q, descend_d;
    logic             signed_q, signed_d;
    logic [CNT_W-1:0] swap_count_q, swap_count_d;
    logic [AW:0]      pass_count_q, pass_count_d;

    logic             busy;
    logic [AW-1:0]    idx_p1;
    logic [AW:0]      idx_p1_ext;
    logic [AW:0]      len_eff;
    logic [WIDTH-1:0] a, b;
    logic             a_gt_b, a_lt_b, out_of_order;
    logic             advance, swapped_now;

    assign busy       = (state_q == StCmp) || (state_q == StSwap);
    assign idx_p1     = idx_q + AW'(1);
    assign idx_p1_ext = {1'b0, idx_q} + (AW+1)'(1);
    assign len_eff    = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;

    // The pair under test stays stable across CMP and SWAP, so SWAP reuses it.
    assign a = mem[idx_q];
    assign b = mem[idx_p1];

    assign a_gt_b = signed_q ? ($signed(a) > $signed(b)) : (a > b);
    assign a_lt_b = signed_q ? ($signed(a) < $signed(b)) : (a < b);
    // Strict compare: equal elements never swap, which keeps the sort stable.
    assign out_of_order = descend_q ? a_lt_b : a_gt_b;

    // Swap writes and host writes never collide: host writes need busy = 0.
    always_ff @(posedge clk) begin
        if (state_q == StSwap) begin
            mem[idx_q]  <= b;
            mem[idx_p1] <= a;
        end else if (bus.wr_en && !busy) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        limit_d      = limit_q;
        swapped_d    = swapped_q;
        descend_d    = descend_q;
        signed_d     = signed_q;
        swap_count_d = swap_count_q;
        pass_count_d = pass_count_q;
        advance      = 1'b0;
        // A swap in this cycle counts towards the end-of-pass decision.
        swapped_now  = swapped_q || (state_q == StSwap);

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    descend_d    = bus.descend;
                    signed_d     = bus.signed_cmp;
                    swap_count_d = '0;
                    pass_count_d = '0;
                    if (len_eff < (AW+1)'(2)) begin
                        state_d = StDone;
                    end else begin
                        idx_d     = '0;
                        limit_d   = len_eff - (AW+1)'(1);
                        swapped_d = 1'b0;
                        state_d   = StCmp;
                    end
                end
            end
            StCmp: begin
                if (out_of_order) begin
                    state_d = StSwap;
                end else begin
                    advance = 1'b1;
                end
            end
            StSwap: begin
                swapped_d = 1'b1;
                if (swap_count_q != {CNT_W{1'b1}}) begin
                    swap_count_d = swap_count_q + CNT_W'(1);
                end
                advance = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            if (idx_p1_ext < limit_q) begin
                idx_d   = idx_p1;
                state_d = StCmp;
            end else begin
                pass_count_d = pass_count_q + (AW+1)'(1);
                if (!swapped_now || (limit_q == (AW+1)'(1))) begin
                    state_d = StDone;
                end else begin
                    limit_d   = limit_q - (AW+1)'(1);
                    idx_d     = '0;
                    swapped_d = 1'b0;
                    state_d   = StCmp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            limit_q      <= '0;
            swapped_q    <= 1'b0;
            descend_q    <= 1'b0;
            signed_q     <= 1'b0;
            swap_count_q <= '0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            limit_q      <= limit_d;
            swapped_q    <= swapped_d;
            descend_q    <= descend_d;
            signed_q     <= signed_d;
            swap_count_q <= swap_count_d;
            pass_count_q <= pass_count_d;
        end
    end

    assign bus.rd_data    = mem[bus.rd_addr];
    assign bus.busy       = busy;
    assign bus.done       = (state_q == StDone);
    assign bus.swap_count = swap_count_q;
    assign bus.pass_count = pass_count_q;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine.
// Stimulus pushes expected completion results and read data into queues; a
// monitor on the falling edge pops and compares when done or a read appears.
module tb_bubble_sort_engine;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        int id;
        int swaps;
        int passes;
        int lat;
        int busy_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rd_req;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] rd_q[$];

    int checks    = 0;
    int failures  = 0;
    int neg_cnt   = 0;
    int start_neg = 0;
    int busy_cnt  = 0;

    always #5 clk = ~clk;

    bubble_sort_engine_if #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W)) bus ();

    bubble_sort_engine #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW),
        .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Monitor: completion results and read data.
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt++;
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_data: read with no expectation queued");
                end else begin
                    check($sformatf("rd_data[%0d]", bus.rd_addr), bus.rd_data, rd_q.pop_front());
                end
            end
            if (bus.start && !bus.busy && !bus.done) begin
                start_neg = neg_cnt;
                busy_cnt  = 0;
            end else if (bus.busy) begin
                busy_cnt++;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done: unexpected done pulse");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("sort%0d swap_count", e.id), 64'(bus.swap_count), 64'(e.swaps));
                    check($sformatf("sort%0d pass_count", e.id), 64'(bus.pass_count), 64'(e.passes));
                    check($sformatf("sort%0d latency", e.id), 64'(neg_cnt - start_neg), 64'(e.lat));
                    check($sformatf("sort%0d busy_cycles", e.id), 64'(busy_cnt), 64'(e.busy_cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input logic [WIDTH-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_check(input int addr, input logic [WIDTH-1:0] d);
        bus.rd_addr = AW'(addr);
        rd_req      = 1'b1;
        rd_q.push_back(d);
        tick();
        rd_req      = 1'b0;
    endtask

    task automatic load4(input logic [WIDTH-1:0] v[4], input int n);
        for (int k = 0; k < n; k++) write_mem(k, v[k]);
    endtask

    task automatic expect4(input logic [WIDTH-1:0] v[4], input int n);
        for (int k = 0; k < n; k++) read_check(k, v[k]);
    endtask

    task automatic run_sort(input int n, input bit desc, input bit sgn, input bit track,
                            input int id, input int swaps, input int passes,
                            input int lat, input int busy_cyc);
        exp_t e;
        e.id       = id;
        e.swaps    = swaps;
        e.passes   = passes;
        e.lat      = lat;
        e.busy_cyc = busy_cyc;
        bus.len        = (AW+1)'(n);
        bus.descend    = desc;
        bus.signed_cmp = sgn;
        bus.start      = 1'b1;
        if (track) exp_q.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
            exp_q.delete();
        end
        tick();
    endtask

    initial begin
        rst_n          = 1'b1;
        rd_req         = 1'b0;
        bus.start      = 1'b0;
        bus.descend    = 1'b0;
        bus.signed_cmp = 1'b0;
        bus.len        = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_addr    = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset swap_count", 64'(bus.swap_count), 64'd0);
        check("reset pass_count", 64'(bus.pass_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // [2,4,0] ascending unsigned.
        load4('{32'd2, 32'd4, 32'd0, 32'd0}, 3);
        run_sort(3, 1'b0, 1'b0, 1'b1, 1, 2, 2, 6, 5);
        wait_done(50);
        expect4('{32'd0, 32'd2, 32'd4, 32'd0}, 3);

        // Already sorted: single pass, no swaps.
        load4('{32'd1, 32'd2, 32'd3, 32'd4}, 4);
        run_sort(4, 1'b0, 1'b0, 1'b1, 2, 0, 1, 4, 3);
        wait_done(50);
        expect4('{32'd1, 32'd2, 32'd3, 32'd4}, 4);

        // Descending, with ignored start/config change and write mid-sort.
        run_sort(4, 1'b1, 1'b0, 1'b1, 3, 6, 3, 13, 12);
        tick();
        tick();
        bus.start   = 1'b1;
        bus.descend = 1'b0;
        bus.len     = (AW+1)'(2);
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = 32'hDEAD_BEEF;
        tick();
        bus.start   = 1'b0;
        bus.wr_en   = 1'b0;
        wait_done(50);
        expect4('{32'd4, 32'd3, 32'd2, 32'd1}, 4);

        // Signed vs unsigned compare.
        load4('{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}, 2);
        run_sort(2, 1'b0, 1'b1, 1'b1, 4, 0, 1, 2, 1);
        wait_done(50);
        expect4('{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}, 2);
        run_sort(2, 1'b0, 1'b0, 1'b1, 5, 1, 1, 3, 2);
        wait_done(50);
        expect4('{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0}, 2);

        // len 0 and 1: immediate done, counts cleared, array untouched.
        run_sort(0, 1'b0, 1'b0, 1'b1, 6, 0, 0, 1, 0);
        wait_done(20);
        run_sort(1, 1'b1, 1'b0, 1'b1, 7, 0, 0, 1, 0);
        wait_done(20);
        expect4('{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0}, 2);

        // len 40 clamps to 32; ascending data sorted descending = worst case.
        for (int k = 0; k < int'(DEPTH); k++) write_mem(k, WIDTH'(k * 7 + 1));
        run_sort(40, 1'b1, 1'b0, 1'b1, 8, 496, 31, 993, 992);
        wait_done(1200);
        for (int k = 0; k < int'(DEPTH); k++) read_check(k, WIDTH'((31 - k) * 7 + 1));

        // Reset during CMP after two swaps, then a fresh sort.
        load4('{32'd4, 32'd3, 32'd2, 32'd1}, 4);
        run_sort(4, 1'b0, 1'b0, 1'b0, 9, 0, 0, 0, 0);
        repeat (4) tick();
        check("mid-sort busy", 64'(bus.busy), 64'd1);
        check("mid-sort swap_count", 64'(bus.swap_count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy", 64'(bus.busy), 64'd0);
        check("async reset done", 64'(bus.done), 64'd0);
        check("async reset swap_count", 64'(bus.swap_count), 64'd0);
        check("async reset pass_count", 64'(bus.pass_count), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        expect4('{32'd3, 32'd2, 32'd4, 32'd1}, 4);
        run_sort(4, 1'b0, 1'b0, 1'b1, 10, 4, 3, 11, 10);
        wait_done(50);
        expect4('{32'd1, 32'd2, 32'd3, 32'd4}, 4);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
